// File: rtl/otter_scoreboard.sv
// otter_scoreboard: per-register outstanding-write counters that stall OTTER decode on RAW/WAW hazards.
// Optional feature: define SB_WB_BYPASS_EN when the register file is write-first, so a same-cycle retiring write clears a source.

module otter_scoreboard (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dec_valid,
   input  logic [31:0] dec_ir,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        flush,
   output logic        reg_en,
   output logic        pc_write,
   output logic        clear,
   output logic [6:0]  inflight,
   output logic        sb_err
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   logic [6:0] opcode;
   logic [4:0] rd;
   logic [2:0] funct3;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic       unused_ir;

   assign opcode    = dec_ir[6:0];
   assign rd        = dec_ir[11:7];
   assign funct3    = dec_ir[14:12];
   assign rs1       = dec_ir[19:15];
   assign rs2       = dec_ir[24:20];
   assign unused_ir = ^dec_ir[31:25];

   // Entry 0 is held at zero so x0 can never look busy or full.
   logic [1:0] cnt     [32];
   logic [1:0] cnt_nxt [32];
   logic [6:0] inflight_nxt;

   logic writes_rd;
   logic reads_rs1;
   logic reads_rs2;

   always_comb begin
      writes_rd = 1'b0;
      reads_rs1 = 1'b0;
      reads_rs2 = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL: begin
            writes_rd = 1'b1;
         end
         OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
            writes_rd = 1'b1;
            reads_rs1 = 1'b1;
         end
         OPC_OP: begin
            writes_rd = 1'b1;
            reads_rs1 = 1'b1;
            reads_rs2 = 1'b1;
         end
         OPC_BRANCH, OPC_STORE: begin
            reads_rs1 = 1'b1;
            reads_rs2 = 1'b1;
         end
         OPC_SYSTEM: begin
            writes_rd = (funct3 != 3'd0);
            reads_rs1 = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd3);
         end
         default: begin
            writes_rd = 1'b0;
         end
      endcase
   end

   logic rs1_busy;
   logic rs2_busy;
   logic rd_full;

   always_comb begin
      rs1_busy = (cnt[rs1] != 2'd0);
      rs2_busy = (cnt[rs2] != 2'd0);
      rd_full  = (cnt[rd] == 2'd3);
`ifdef SB_WB_BYPASS_EN
      // The last outstanding write lands this cycle and the register file forwards it.
      if (wb_valid && (wb_rd == rs1) && (cnt[rs1] == 2'd1)) begin
         rs1_busy = 1'b0;
      end
      if (wb_valid && (wb_rd == rs2) && (cnt[rs2] == 2'd1)) begin
         rs2_busy = 1'b0;
      end
`endif
   end

   logic hazard;
   logic issue;
   logic wb_ok;
   logic wb_orphan;

   // Reset forces the pipeline to advance so a stall can never outlive reset.
   assign hazard = rst_n & dec_valid & ~flush &
                   ((reads_rs1 & rs1_busy) | (reads_rs2 & rs2_busy) | (writes_rd & rd_full));

   assign reg_en   = ~hazard;
   assign pc_write = ~hazard;
   assign clear    = hazard;

   assign issue     = dec_valid & ~hazard & ~flush & writes_rd & (rd != 5'd0);
   assign wb_ok     = wb_valid & (wb_rd != 5'd0) & (cnt[wb_rd] != 2'd0);
   assign wb_orphan = wb_valid & (wb_rd != 5'd0) & (cnt[wb_rd] == 2'd0);

   always_comb begin
      inflight_nxt = 7'd0;
      for (int i = 0; i < 32; i++) begin
         cnt_nxt[i] = cnt[i];
         if (i == 0 || flush) begin
            cnt_nxt[i] = 2'd0;
         end else if (issue && (rd == 5'(i)) && !(wb_ok && (wb_rd == 5'(i)))) begin
            cnt_nxt[i] = cnt[i] + 2'd1;
         end else if (wb_ok && (wb_rd == 5'(i)) && !(issue && (rd == 5'(i)))) begin
            cnt_nxt[i] = cnt[i] - 2'd1;
         end
         inflight_nxt = inflight_nxt + {5'd0, cnt_nxt[i]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            cnt[i] <= 2'd0;
         end
         inflight <= 7'd0;
         sb_err   <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         inflight <= inflight_nxt;
         if (wb_orphan) begin
            sb_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_otter_scoreboard.sv
// tb_otter_scoreboard: directed vectors against a register-count model of the OTTER scoreboard.
// Define SB_WB_BYPASS_EN consistently for bench and RTL to exercise the bypass build.

module tb_otter_scoreboard;

   logic        clk;
   logic        rst_n;
   logic        dec_valid;
   logic [31:0] dec_ir;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic        flush;
   logic        reg_en;
   logic        pc_write;
   logic        clear;
   logic [6:0]  inflight;
   logic        sb_err;

   int total;
   int bad;

   otter_scoreboard dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dec_valid (dec_valid),
      .dec_ir    (dec_ir),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .flush     (flush),
      .reg_en    (reg_en),
      .pc_write  (pc_write),
      .clear     (clear),
      .inflight  (inflight),
      .sb_err    (sb_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   localparam logic [31:0] ADDI_X5  = 32'h00100293;
   localparam logic [31:0] ADD_X6   = 32'h00528333;
   localparam logic [31:0] LW_X7    = 32'h00002383;
   localparam logic [31:0] ADDI_X1  = 32'h00100093;
   localparam logic [31:0] ADDI_X2  = 32'h00100113;
   localparam logic [31:0] ADDI_X3  = 32'h00100193;
   localparam logic [31:0] ADDI_X4  = 32'h00100213;
   localparam logic [31:0] LUI_X0   = 32'h00001037;
   localparam logic [31:0] SW_X0    = 32'h00002023;

   // Model state: outstanding writes per architectural register.
   int cnt_m [32];
   int nc    [32];
   int inflight_m;
   bit err_m;
   bit seen_reset;

   function automatic bit m_writes(logic [31:0] ir);
      logic [6:0] op;
      op = ir[6:0];
      return (op inside {7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h33}) ||
             (op == 7'h73 && ir[14:12] != 3'd0);
   endfunction

   function automatic bit m_reads1(logic [31:0] ir);
      logic [6:0] op;
      op = ir[6:0];
      return (op inside {7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33}) ||
             (op == 7'h73 && ir[14:12] inside {3'd1, 3'd2, 3'd3});
   endfunction

   function automatic bit m_reads2(logic [31:0] ir);
      return ir[6:0] inside {7'h63, 7'h23, 7'h33};
   endfunction

   function automatic bit m_pending(int r);
      if (r == 0 || cnt_m[r] == 0) return 1'b0;
`ifdef SB_WB_BYPASS_EN
      if (cnt_m[r] == 1 && wb_valid && int'(wb_rd) == r) return 1'b0;
`endif
      return 1'b1;
   endfunction

   function automatic bit m_hazard();
      int s1, s2, d;
      s1 = int'(dec_ir[19:15]);
      s2 = int'(dec_ir[24:20]);
      d  = int'(dec_ir[11:7]);
      if (!rst_n || !dec_valid || flush) return 1'b0;
      return (m_reads1(dec_ir) && m_pending(s1)) ||
             (m_reads2(dec_ir) && m_pending(s2)) ||
             (m_writes(dec_ir) && d != 0 && cnt_m[d] >= 3);
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) cnt_m[i] = 0;
      inflight_m = 0;
      err_m      = 1'b0;
      seen_reset = 1'b0;
   end

   always @(posedge clk) begin
      int d, sum;
      bit hz;
      for (int i = 0; i < 32; i++) nc[i] = cnt_m[i];
      d  = int'(dec_ir[11:7]);
      hz = m_hazard();
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) nc[i] = 0;
         err_m      <= 1'b0;
         seen_reset <= 1'b1;
      end else begin
         if (wb_valid && wb_rd != 5'd0 && cnt_m[wb_rd] == 0) err_m <= 1'b1;
         if (flush) begin
            for (int i = 0; i < 32; i++) nc[i] = 0;
         end else begin
            if (wb_valid && wb_rd != 5'd0 && cnt_m[wb_rd] > 0) nc[wb_rd] = nc[wb_rd] - 1;
            if (dec_valid && !hz && m_writes(dec_ir) && d != 0) nc[d] = nc[d] + 1;
         end
      end
      sum = 0;
      for (int i = 0; i < 32; i++) sum += nc[i];
      cnt_m      <= nc;
      inflight_m <= sum;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic compareModel();
      bit hz;
      hz = m_hazard();
      if (seen_reset) begin
         checkOutput("model.reg_en",   int'(reg_en),   int'(!hz));
         checkOutput("model.pc_write", int'(pc_write), int'(!hz));
         checkOutput("model.clear",    int'(clear),    int'(hz));
         checkOutput("model.inflight", int'(inflight), inflight_m);
         checkOutput("model.sb_err",   int'(sb_err),   int'(err_m));
      end
   endtask

   // Inputs change just after the rising edge; outputs are judged at the falling edge.
   task automatic applyStimulus(input bit rst, input bit v, input logic [31:0] ir,
                                input bit wv, input logic [4:0] wr, input bit fl);
      @(posedge clk);
      #1;
      rst_n     = rst;
      dec_valid = v;
      dec_ir    = ir;
      wb_valid  = wv;
      wb_rd     = wr;
      flush     = fl;
      @(negedge clk);
      compareModel();
   endtask

   task automatic bubble();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      dec_valid = 1'b0;
      dec_ir    = 32'h0;
      wb_valid  = 1'b0;
      wb_rd     = 5'd0;
      flush     = 1'b0;

      applyStimulus(1'b0, 1'b1, ADD_X6, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b0, 1'b1, ADD_X6, 1'b0, 5'd0, 1'b0);
      checkOutput("reset.reg_en", int'(reg_en), 1);
      checkOutput("reset.clear", int'(clear), 0);
      checkOutput("reset.inflight", int'(inflight), 0);
      checkOutput("reset.sb_err", int'(sb_err), 0);

      // RAW on x5 held until its write retires.
      applyStimulus(1'b1, 1'b1, ADDI_X5, 1'b0, 5'd0, 1'b0);
      checkOutput("raw.issue_reg_en", int'(reg_en), 1);
      applyStimulus(1'b1, 1'b1, ADD_X6, 1'b0, 5'd0, 1'b0);
      checkOutput("raw.inflight1", int'(inflight), 1);
      checkOutput("raw.stall_reg_en", int'(reg_en), 0);
      checkOutput("raw.stall_clear", int'(clear), 1);
      applyStimulus(1'b1, 1'b1, ADD_X6, 1'b1, 5'd5, 1'b0);
`ifdef SB_WB_BYPASS_EN
      checkOutput("bypass.reg_en", int'(reg_en), 1);
      bubble();
      checkOutput("bypass.inflight", int'(inflight), 1);
`else
      checkOutput("nobypass.reg_en", int'(reg_en), 0);
      applyStimulus(1'b1, 1'b1, ADD_X6, 1'b0, 5'd0, 1'b0);
      checkOutput("nobypass.next_reg_en", int'(reg_en), 1);
      checkOutput("nobypass.inflight0", int'(inflight), 0);
`endif
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 5'd6, 1'b0);
      bubble();
      checkOutput("raw.drained", int'(inflight), 0);

      // WAW saturation on x7.
      repeat (3) applyStimulus(1'b1, 1'b1, LW_X7, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, LW_X7, 1'b0, 5'd0, 1'b0);
      checkOutput("waw.inflight3", int'(inflight), 3);
      checkOutput("waw.stall", int'(reg_en), 0);
      applyStimulus(1'b1, 1'b1, LW_X7, 1'b1, 5'd7, 1'b0);
      applyStimulus(1'b1, 1'b1, LW_X7, 1'b0, 5'd0, 1'b0);
      checkOutput("waw.after_wb_inflight", int'(inflight), 2);
      checkOutput("waw.after_wb_reg_en", int'(reg_en), 1);
      bubble();
      checkOutput("waw.refilled", int'(inflight), 3);
      repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 5'd7, 1'b0);
      bubble();
      checkOutput("waw.drained", int'(inflight), 0);
      checkOutput("waw.no_err", int'(sb_err), 0);

      // Flush beats issue and writeback.
      applyStimulus(1'b1, 1'b1, ADDI_X1, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, ADDI_X2, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, ADDI_X3, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, ADDI_X4, 1'b1, 5'd1, 1'b1);
      checkOutput("flush.before", int'(inflight), 3);
      bubble();
      checkOutput("flush.after", int'(inflight), 0);
      checkOutput("flush.no_err", int'(sb_err), 0);

      // Orphan writeback is sticky until reset.
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 5'd12, 1'b0);
      bubble();
      checkOutput("orphan.err", int'(sb_err), 1);
      checkOutput("orphan.inflight", int'(inflight), 0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 5'd0, 1'b1);
      bubble();
      checkOutput("orphan.held", int'(sb_err), 1);

      // x0 traffic and bubbles never stall.
      applyStimulus(1'b1, 1'b1, ADDI_X5, 1'b0, 5'd0, 1'b0);
      applyStimulus(1'b1, 1'b1, LUI_X0, 1'b0, 5'd0, 1'b0);
      checkOutput("x0.lui", int'(reg_en), 1);
      applyStimulus(1'b1, 1'b1, SW_X0, 1'b0, 5'd0, 1'b0);
      checkOutput("x0.sw", int'(reg_en), 1);
      applyStimulus(1'b1, 1'b0, ADD_X6, 1'b0, 5'd0, 1'b0);
      checkOutput("x0.bubble", int'(reg_en), 1);
      checkOutput("x0.inflight", int'(inflight), 1);

      // Reset in the middle of a stall.
      applyStimulus(1'b1, 1'b1, ADD_X6, 1'b0, 5'd0, 1'b0);
      checkOutput("midreset.stall", int'(reg_en), 0);
      applyStimulus(1'b0, 1'b1, ADD_X6, 1'b1, 5'd5, 1'b1);
      checkOutput("midreset.release", int'(reg_en), 1);
      checkOutput("midreset.clear", int'(clear), 0);
      bubble();
      checkOutput("midreset.inflight", int'(inflight), 0);
      checkOutput("midreset.err", int'(sb_err), 0);
      applyStimulus(1'b1, 1'b1, ADD_X6, 1'b0, 5'd0, 1'b0);
      checkOutput("midreset.free", int'(reg_en), 1);
      bubble();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/otter_scoreboard.md
OTTER_SCOREBOARD -- requirements
Module: otter_scoreboard

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst_n  in  1  synchronous, active-low reset; sampled on rising clk.
REQ-003 dec_valid  in  1  decode stage holds a real instruction (0 = bubble).
REQ-004 dec_ir  in  32  instruction in decode: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20].
REQ-005 wb_valid  in  1  a register write retires this cycle.
REQ-006 wb_rd  in  5  destination register of the retiring write.
REQ-007 flush  in  1  discard all in-flight writes (branch/jump redirect).
REQ-008 reg_en  out  1  1 = decode/fetch registers advance; 0 = hold.
REQ-009 pc_write  out  1  1 = PC updates; equals reg_en.
REQ-010 clear  out  1  1 = inject bubble into execute register; equals ~reg_en.
REQ-011 inflight  out  7  total count of outstanding register writes, 0..93.
REQ-012 sb_err  out  1  sticky: writeback retired with no matching outstanding write.

Function
REQ-013 Each register x1..x31 SHALL own a 2-bit outstanding-write counter; x0 SHALL never be counted, and rd=0 SHALL never cause a hazard.
REQ-014 Writes rd: LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, and SYSTEM with funct3 != 0.
REQ-015 Reads rs1: JALR, BRANCH, LOAD, STORE, OP_IMM, OP, and SYSTEM with funct3 in {1,2,3}.
REQ-016 Reads rs2: BRANCH, STORE, OP; unlisted opcodes read and write nothing.
REQ-017 hazard (combinational) = dec_valid & ~flush & (rs1 used & count[rs1]!=0 | rs2 used & count[rs2]!=0 | rd written & count[rd]==3).
REQ-018 reg_en = pc_write = ~hazard; clear = hazard; same-cycle response, no added latency.
REQ-019 Issue = dec_valid & ~hazard & ~flush & rd written & rd!=0; issue SHALL increment count[rd] at the next edge.
REQ-020 wb_valid & wb_rd!=0 & count[wb_rd]!=0 SHALL decrement count[wb_rd] at the next edge.
REQ-021 Issue and writeback to the same register in one cycle SHALL leave its count unchanged.
REQ-022 wb_valid with wb_rd!=0 and count[wb_rd]==0 SHALL leave counts unchanged and set sb_err next edge; sb_err clears only on reset.
REQ-023 flush SHALL zero all counters next edge, overriding same-cycle issue and writeback; sb_err is unaffected.
REQ-024 Count 3 with another write to the same rd is a WAW saturation stall per REQ-017; counters SHALL never wrap.
REQ-025 inflight SHALL be registered and equal to the sum of all counters after each edge.

Reset
REQ-026 rst_n=0 at an edge SHALL zero all counters, inflight=0, sb_err=0; it overrides flush, issue, and writeback.
REQ-027 While rst_n=0, outputs SHALL be reg_en=1, pc_write=1, clear=0, regardless of dec_ir.
REQ-028 Reset asserted mid-stall SHALL release the stall in the same cycle, and all state SHALL be clear after the edge.

Configuration
REQ-029 SB_WB_BYPASS_EN defined: a source register with count==1 and wb_valid & wb_rd match this cycle SHALL be treated as not pending (write-first register file).
REQ-030 SB_WB_BYPASS_EN undefined: that case SHALL stall for one cycle, and the decode instruction SHALL proceed the following cycle.

Verification
REQ-031 Reset; issue addi x5,x0,1 (0x00100293); next cycle decode add x6,x5,x5 -> hazard=1, reg_en=0, clear=1 until wb_rd=5 retires; inflight 1->0.
REQ-032 Issue lw x7 three times with no writeback; 4th lw x7 -> stall (count saturates at 3, inflight=3); one wb_rd=7 -> 4th issues, inflight stays 3.
REQ-033 count[9]=1; same cycle wb_rd=9 and decode reads x9 -> with macro: reg_en=1; without: reg_en=0 that cycle, 1 the next.
REQ-034 inflight=3 across x1,x2,x3; assert flush together with issue of x4 and wb_rd=1 -> inflight=0 next cycle, no sb_err.
REQ-035 wb_valid with wb_rd=12 and count[12]=0 -> sb_err=1 next cycle and held; counts unchanged; rst_n=0 -> sb_err=0.
REQ-036 Decode lui x0 / sw x0,0(x0) / dec_valid=0 with matching fields -> hazard never asserted, inflight unchanged.
